act_tile_arbiter: RTL and testbench

//  Shares one Activation unit (sign-magnitude 8-bit ReLU path) between N accumulator channels.

---
 rtl/act_tile_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_act_tile_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_tile_arbiter.sv
// Round-robin, per-tile arbiter that shares one Activation unit between N_CH
// accumulator channels and tags every returning result beat with its owning channel.
module act_tile_arbiter #(
  parameter int N_CH      = 4,
  parameter int DW        = 8,
  parameter int TAG_DEPTH = 4,
  parameter int IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid_i,
  input  logic [N_CH-1:0]      req_last_i,
  input  logic [N_CH*DW-1:0]   req_data_i,
  output logic [N_CH-1:0]      req_ready_o,
  output logic                 acc_valid_o,
  output logic                 acc_last_o,
  output logic [DW-1:0]        acc_result_o,
  input  logic                 act_valid_i,
  input  logic                 act_last_i,
  input  logic [DW-1:0]        act_result_i,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  output logic [DW-1:0]        out_result_o,
  output logic [IDW-1:0]       out_id_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            acc_valid_q, acc_valid_d;
  logic            acc_last_q, acc_last_d;
  logic [DW-1:0]   acc_result_q, acc_result_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  tag_q [TAG_DEPTH];
  logic [IDW-1:0]  tag_d [TAG_DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   ch_data_s [N_CH];
  logic [N_CH-1:0] ready_s;
  logic [IDW-1:0]  pick_s;
  logic            any_req_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            xfer_s;

  function automatic logic [IDW-1:0] ch_inc(input logic [IDW-1:0] c);
    return (c == IDW'(N_CH - 1)) ? '0 : c + IDW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_slice
    assign ch_data_s[c] = req_data_i[c*DW +: DW];
  end

  assign any_req_s    = |req_valid_i;
  assign fifo_empty_s = (cnt_q == '0);
  assign fifo_full_s  = (cnt_q == CW'(TAG_DEPTH));

  // Round-robin search: first valid channel upward from rr_q+1, wrapping at N_CH.
  always_comb begin
    logic [IDW-1:0] c_v;
    logic           found_v;
    logic           hit_v;
    pick_s  = '0;
    found_v = 1'b0;
    c_v     = ch_inc(rr_q);
    for (int i = 0; i < N_CH; i++) begin
      hit_v   = req_valid_i[c_v] & ~found_v;
      pick_s  = hit_v ? c_v : pick_s;
      found_v = found_v | hit_v;
      c_v     = ch_inc(c_v);
    end
  end

  // FSM, Activation-side staging register and tile-id FIFO next state.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    ready_s      = '0;
    push_s       = 1'b0;
    xfer_s       = 1'b0;
    tag_d        = tag_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_s && !fifo_full_s) begin
          push_s  = 1'b1;
          gnt_d   = pick_s;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        ready_s[gnt_q] = 1'b1;
        xfer_s         = req_valid_i[gnt_q];
        if (xfer_s && req_last_i[gnt_q]) begin
          rr_d    = gnt_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_GRANT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    acc_valid_d  = xfer_s;
    acc_last_d   = xfer_s ? req_last_i[gnt_q] : acc_last_q;
    acc_result_d = xfer_s ? ch_data_s[gnt_q]  : acc_result_q;

    // A beat arriving with no tile outstanding is flagged and never pops.
    pop_s = act_valid_i & act_last_i & ~fifo_empty_s;
    err_d = err_q | (act_valid_i & fifo_empty_s);

    if (push_s) begin
      tag_d[wr_q] = pick_s;
      wr_d        = ptr_inc(wr_q);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = ptr_inc(rd_q);
    end else begin
      rd_d = rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State and datapath registers; reset drops any partial tile immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      rr_q         <= IDW'(N_CH - 1);
      acc_valid_q  <= 1'b0;
      acc_last_q   <= 1'b0;
      acc_result_q <= '0;
      err_q        <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      acc_valid_q  <= acc_valid_d;
      acc_last_q   <= acc_last_d;
      acc_result_q <= acc_result_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
    end
  end

  assign req_ready_o  = ready_s;
  assign acc_valid_o  = acc_valid_q;
  assign acc_last_o   = acc_last_q;
  assign acc_result_o = acc_result_q;
  // Return path is combinational but held at zero while reset is asserted.
  assign out_valid_o  = rst & act_valid_i;
  assign out_last_o   = rst & act_last_i;
  assign out_result_o = rst ? act_result_i : '0;
  assign out_id_o     = fifo_empty_s ? '0 : tag_q[rd_q];
  assign busy_o       = (state_q == S_GRANT);
  assign err_o        = err_q;

endmodule

// File: tb/tb_act_tile_arbiter.sv
// Scoreboard bench for act_tile_arbiter with a ReLU stand-in for the Activation unit.
module tb_act_tile_arbiter;
  localparam int N_CH = 4, DW = 8, TAG_DEPTH = 4, IDW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_CH-1:0]     req_valid_i, req_last_i, req_ready_o;
  logic [N_CH*DW-1:0]  req_data_i;
  logic                acc_valid_o, acc_last_o;
  logic [DW-1:0]       acc_result_o;
  logic                act_valid_i, act_last_i;
  logic [DW-1:0]       act_result_i;
  logic                out_valid_o, out_last_o;
  logic [DW-1:0]       out_result_o;
  logic [IDW-1:0]      out_id_o;
  logic                busy_o, err_o;

  logic                model_on, man_valid, man_last;
  logic [DW-1:0]       man_result;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  assign act_valid_i  = model_on ? acc_valid_o : man_valid;
  assign act_last_i   = model_on ? acc_last_o : man_last;
  assign act_result_i = model_on ? relu(acc_result_o) : man_result;

  act_tile_arbiter #(.N_CH(N_CH), .DW(DW), .TAG_DEPTH(TAG_DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .acc_valid_o(acc_valid_o), .acc_last_o(acc_last_o), .acc_result_o(acc_result_o),
    .act_valid_i(act_valid_i), .act_last_i(act_last_i), .act_result_i(act_result_i),
    .out_valid_o(out_valid_o), .out_last_o(out_last_o), .out_result_o(out_result_o),
    .out_id_o(out_id_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic bub; logic last; logic [DW-1:0] data; } beat_t;
  typedef struct { int id; logic [DW-1:0] data; logic last; int cyc; } exp_t;

  beat_t chq [N_CH][$];
  exp_t  sb[$];
  int    grants[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, n_out = 0, idle_run = 0;
  logic  prev_busy = 1'b0, gap_chk = 1'b0;
  logic  gap4_on = 1'b0, acc_seen = 1'b0, acc_done = 1'b0;
  int    acc_gaps = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int first_set(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < N_CH; c++) begin
      if (chq[c].size() > 0 && !chq[c][0].bub) begin
        req_valid_i[c]          = 1'b1;
        req_last_i[c]           = chq[c][0].last;
        req_data_i[c*DW +: DW]  = chq[c][0].data;
      end else begin
        req_valid_i[c]          = 1'b0;
        req_last_i[c]           = 1'b0;
        req_data_i[c*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic add_beat(input int c, input logic [DW-1:0] d, input logic last);
    chq[c].push_back({1'b0, last, d});
  endtask

  task automatic add_bub(input int c, input int n);
    for (int i = 0; i < n; i++) chq[c].push_back({1'b1, 1'b0, {DW{1'b0}}});
  endtask

  task automatic add_tile(input int c, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) add_beat(c, base + DW'(i), (i == n - 1));
  endtask

  task automatic tick();
    logic [N_CH-1:0] took;
    exp_t e;
    took = req_ready_o & req_valid_i;
    for (int c = 0; c < N_CH; c++) begin
      if (took[c]) begin
        if (model_on) sb.push_back('{id: c, data: chq[c][0].data, last: chq[c][0].last, cyc: cyc + 1});
        void'(chq[c].pop_front());
      end else if (chq[c].size() > 0 && chq[c][0].bub) begin
        void'(chq[c].pop_front());
      end
    end
    @(posedge clk); #1; cyc++;
    check_val("ready_onehot", 32'($countones(req_ready_o) <= 1), 32'd1);
    if (busy_o && !prev_busy) begin
      if (gap_chk && grants.size() > 0) check_val("idle_gap", idle_run, 1);
      grants.push_back(first_set(req_ready_o));
      idle_run = 0;
    end else if (!busy_o) begin
      idle_run++;
    end
    prev_busy = busy_o;
    if (gap4_on && !acc_done) begin
      if (acc_valid_o) begin
        acc_seen = 1'b1;
        if (acc_last_o) acc_done = 1'b1;
      end else if (acc_seen) begin
        acc_gaps++;
      end
    end
    if (model_on && out_valid_o) begin
      n_out++;
      if (sb.size() == 0) begin
        check_val("sb_unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("acc_result", acc_result_o, e.data);
        check_val("acc_last", acc_last_o, e.last);
        check_val("out_result", out_result_o, relu(e.data));
        check_val("out_last", out_last_o, e.last);
        check_val("out_id", out_id_o, e.id);
        check_val("acc_latency", cyc, e.cyc);
      end
    end
    drive_inputs();
  endtask

  task automatic run(input int max, input string tag);
    int n = 0;
    logic pending;
    pending = 1'b1;
    while (pending && n < max) begin
      pending = busy_o || (sb.size() > 0);
      for (int c = 0; c < N_CH; c++) if (chq[c].size() > 0) pending = 1'b1;
      if (pending) begin tick(); n++; end
    end
    if (pending) check_val({tag, "_timeout"}, 1, 0);
  endtask

  task automatic clear_all();
    for (int c = 0; c < N_CH; c++) chq[c].delete();
    sb.delete(); grants.delete();
    prev_busy = 1'b0; idle_run = 0; n_out = 0;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0; model_on = 1'b0; man_valid = 1'b0; man_last = 1'b0; man_result = '0;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_ready"}, req_ready_o, 0);
    check_val({tag, "_acc"}, {acc_valid_o, acc_last_o, acc_result_o}, 0);
    check_val({tag, "_out"}, {out_valid_o, out_last_o, out_result_o, out_id_o}, 0);
    check_val({tag, "_busy_err"}, {busy_o, err_o}, 0);
  endtask

  task automatic pop_check(input int exp_id, input logic last);
    man_valid = 1'b1; man_last = last; man_result = 8'h33;
    #1;
    check_val("pop_out_valid", {out_valid_o, out_last_o, out_result_o}, {1'b1, last, 8'h33});
    check_val("pop_out_id", out_id_o, exp_id);
    tick();
    man_valid = 1'b0; man_last = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    logic saw;
    // 1: reset state, mid-tile reset, first grant to ch0
    rst = 1'b0; model_on = 1'b0; man_valid = 1'b0; man_last = 1'b0; man_result = '0;
    clear_all();
    #2 check_zero("reset_state");
    @(posedge clk); #1 rst = 1'b1;
    add_tile(0, 4, 8'h5A); add_tile(2, 4, 8'h20);
    drive_inputs();
    tick();
    check_val("t1_first_grant", req_ready_o, 4'b0001);
    tick(); tick();
    check_val("t1_acc_before_reset", acc_result_o, 8'h5B);
    rst = 1'b0;
    #1 check_zero("t1_mid_reset");
    clear_all();
    #3 rst = 1'b1;
    add_tile(1, 2, 8'h10); add_tile(0, 3, 8'h01);
    drive_inputs();
    run(100, "t1_run");
    check_val("t1_grants", {32'(grants.size()), 32'(grants[0]), 32'(grants[1])}, {32'd2, 32'd0, 32'd1});

    // 2: single 16-beat tile on ch1 through the ReLU model
    do_reset(); model_on = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic neg;
      neg = (i >= 5 && i <= 8) || (i >= 13);
      add_beat(1, {neg, 7'(i)}, (i == 16));
    end
    drive_inputs();
    run(100, "t2_run");
    check_val("t2_beats", n_out, 16);
    check_val("t2_grant", grants[0], 1);

    // 3: round-robin with all channels busy
    do_reset(); model_on = 1'b1; gap_chk = 1'b1;
    for (int c = 0; c < N_CH; c++) add_tile(c, 4, DW'(c * 16));
    add_tile(0, 4, 8'h88);
    drive_inputs();
    run(200, "t3_run");
    gap_chk = 1'b0;
    exp_order = '{0, 1, 2, 3, 0};
    check_val("t3_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check_val("t3_grant_order", grants[i], exp_order[i]);
    check_val("t3_beats", n_out, 20);

    // 4: bubble on ch2 while ch0 waits
    do_reset(); model_on = 1'b1;
    gap4_on = 1'b1; acc_seen = 1'b0; acc_done = 1'b0; acc_gaps = 0;
    add_beat(2, 8'h41, 1'b0); add_beat(2, 8'hC2, 1'b0); add_bub(2, 2);
    add_beat(2, 8'h43, 1'b0); add_beat(2, 8'h44, 1'b1);
    add_bub(0, 3); add_tile(0, 4, 8'h70);
    drive_inputs();
    run(100, "t4_run");
    gap4_on = 1'b0;
    check_val("t4_acc_gap", acc_gaps, 2);
    check_val("t4_grants", {32'(grants.size()), 32'(grants[0]), 32'(grants[1])}, {32'd2, 32'd2, 32'd0});

    // 5: tag FIFO full stalls arbitration until a pop
    do_reset();
    for (int c = 0; c < N_CH; c++) add_tile(c, 2, DW'(c * 4));
    add_tile(0, 2, 8'h60);
    drive_inputs();
    begin
      int n = 0;
      while ((grants.size() < 4 || busy_o) && n < 100) begin tick(); n++; end
      if (n >= 100) check_val("t5_fill_timeout", 1, 0);
    end
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw = saw | busy_o | (|req_ready_o);
    end
    check_val("t5_stall_while_full", saw, 1'b0);
    check_val("t5_ch0_waiting", req_valid_i[0], 1'b1);
    pop_check(0, 1'b1);
    check_val("t5_no_grant_in_pop_cycle", req_ready_o, 0);
    tick();
    check_val("t5_grant_after_pop", req_ready_o, 4'b0001);
    run(50, "t5_fifth_tile");
    pop_check(1, 1'b0);
    pop_check(1, 1'b1);
    pop_check(2, 1'b1);
    pop_check(3, 1'b1);
    pop_check(0, 1'b1);
    check_val("t5_grants", grants.size(), 5);
    #1 check_val("t5_empty_id", {out_id_o, err_o}, 0);

    // 6: result beat with nothing issued
    do_reset();
    man_valid = 1'b1; man_last = 1'b1; man_result = 8'h07;
    #1;
    check_val("t6_id_empty", out_id_o, 0);
    check_val("t6_err_before", err_o, 0);
    tick();
    man_valid = 1'b0; man_last = 1'b0;
    check_val("t6_err_set", err_o, 1);
    repeat (3) tick();
    check_val("t6_err_sticky", {err_o, out_id_o}, {1'b1, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
